unidad_control_multiciclo: RTL and testbench
============================================

Name: unidad_control_multiciclo

Overview:
- Multi-cycle, FSM-based main control unit for the datapath. It replaces the single-cycle R-type-only decoder.
- Decodes opcode and funct, then sequences one instruction over 3–5 states.
- Drives PC, instruction-register, register-file, memory and ALU control.
- Stalls on a memory ready handshake. Flags illegal opcodes.

Parameters:
- OPCODE_W, 6, opcode field width
- FUNCT_W, 6, funct field width
- ALU_CTRL_W, 3, ALU control width (codes below fit in 3 bits; wider values are zero-extended)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start/continue execution from IDLE
- OPcode  in  OPCODE_W  instruction opcode (from IR)
- funct  in  FUNCT_W  R-type funct field (from IR)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- pc_write  out  1  PC load
- ir_write  out  1  instruction register load
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write
- mem_to_reg  out  1  1 = writeback from memory data
- reg_dst  out  1  1 = rd, 0 = rt
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
- alu_control  out  ALU_CTRL_W  ALU operation
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse at instruction completion
- illegal_op  out  1  one-cycle pulse on unknown opcode
- state_o  out  4  current state encoding, for debug

Behaviour:
- Reset (async, rst_n = 0): state = IDLE. All outputs are 0 and remain 0 while in IDLE.
- Outputs are Moore, decoded from state, except the mem_ready/zero qualifications noted below.
- ALU codes: AND = 000, OR = 001, ADD = 010, SUB = 110, SLT = 111.
- Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, ADDI = 001000, J = 000010.
- IDLE: moves to FETCH when en = 1, otherwise stays in IDLE.
- FETCH: mem_read = 1, alu_src_a = 0, alu_src_b = 01, ADD, pc_source = 00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH until mem_ready = 1, then goes to DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 11, ADD (branch target into ALUOut). Next state by opcode:
  - R → EXEC_R
  - LW or SW → MEM_ADDR
  - BEQ → BRANCH
  - ADDI → EXEC_I
  - J → JUMP
  - other → FETCH, with illegal_op = 1 for exactly that DECODE cycle
- EXEC_R: alu_src_a = 1, alu_src_b = 00. ALU op from funct:
  - 100000 → ADD
  - 100010 → SUB
  - 100100 → AND
  - 100101 → OR
  - 101010 → SLT
  - other funct → ADD (no flag)
  - Next state: WB_R.
- WB_R: reg_write = 1, reg_dst = 1, mem_to_reg = 0, instr_done = 1 → FETCH.
- EXEC_I: alu_src_a = 1, alu_src_b = 10, ADD → WB_I.
- WB_I: reg_write = 1, reg_dst = 0, mem_to_reg = 0, instr_done = 1 → FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, ADD → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read = 1; waits until mem_ready = 1, then → WB_MEM.
- WB_MEM: reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1 → FETCH.
- MEM_WR: mem_write = 1; waits until mem_ready = 1.
  - instr_done = mem_ready, then → FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, SUB, pc_source = 01.
  - pc_write = zero, instr_done = 1 → FETCH.
- JUMP: pc_source = 10, pc_write = 1, instr_done = 1 → FETCH.
- en is sampled only in IDLE. Deasserting en never aborts an instruction in flight.
- mem_read and mem_write are held stable for the whole wait. No other output changes during a wait.
- mem_read and mem_write are never asserted together. reg_write and pc_write are never asserted together except in FETCH, where reg_write = 0.
- Latency with mem_ready = 1 from FETCH entry to instr_done, in cycles: R = 4, ADDI = 4, LW = 5, SW = 4, BEQ = 3, J = 3.
- Reset mid-instruction: immediate return to IDLE, outputs 0, no partial writeback.
- Unused state encodings → IDLE on the next edge.

Decomposition:
- Package control_pkg holds:
  - opcode and funct localparams
  - ALU code localparams
  - 4-bit state encoding
  - alu_src_b and pc_source code constants
- Sub-module control_alu_decoder is combinational (ALU op class + funct → alu_control).
  - Op classes: ADD, SUB, FUNCT.
  - The FSM drives the op class; the decoder also serves future units.

Test Plan:
1. Reset then en = 1, mem_ready = 1, OPcode = 000000, funct = 100010:
   - FETCH→DECODE→EXEC_R→WB_R.
   - alu_control = 110 in EXEC_R.
   - reg_write = 1, reg_dst = 1 in WB_R.
   - instr_done on cycle 4.
2. LW (100011) with mem_ready low for 3 cycles in MEM_RD:
   - mem_read = 1 held 4 cycles.
   - Then WB_MEM with mem_to_reg = 1, reg_write = 1.
   - Total latency 8 cycles.
3. BEQ (000100):
   - With zero = 1: pc_write = 1, pc_source = 01 in BRANCH.
   - With zero = 0: pc_write = 0 in BRANCH.
   - instr_done = 1 in both cases.
4. OPcode = 111111: illegal_op pulses 1 cycle in DECODE, next state FETCH, no reg_write or mem_write asserted.
5. SW (101011), rst_n pulled low during MEM_WR wait: outputs 0 immediately, state_o = IDLE, mem_write never completes.
6. J (000010) then en = 0: pc_write = 1, pc_source = 10 in JUMP. The FSM continues to FETCH, since en is not re-sampled outside IDLE.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle main control unit: opcodes, funct codes,
// ALU codes, mux selects, FSM state encoding and the control-word payload.
package control_pkg;

  localparam int unsigned OP_W      = 6;
  localparam int unsigned FN_W      = 6;
  localparam int unsigned ALU_W     = 3;
  localparam int unsigned STATE_W   = 4;
  localparam int unsigned MUX_SEL_W = 2;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  localparam logic [MUX_SEL_W-1:0] SRCB_REG     = 2'b00;
  localparam logic [MUX_SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [MUX_SEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [MUX_SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [MUX_SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [MUX_SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [MUX_SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_e;

  typedef struct packed {
    logic                 pc_write;
    logic                 ir_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 reg_dst;
    logic                 alu_src_a;
    logic [MUX_SEL_W-1:0] alu_src_b;
    logic [MUX_SEL_W-1:0] pc_source;
    logic                 instr_done;
    logic                 illegal_op;
    logic                 alu_active;
    alu_op_e              alu_op;
  } ctrl_t;

endpackage

// File: rtl/control_alu_decoder.sv
// Maps an ALU operation class plus the R-type funct field to an ALU control code.
module control_alu_decoder
  import control_pkg::*;
#(
  parameter int unsigned FUNCT_W    = 6,
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  alu_op_e               alu_op_i,
  input  logic [FUNCT_W-1:0]    funct_i,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_c_o
);

  logic [ALU_W-1:0] code;

  // Unknown funct values fall back to ADD without raising any flag.
  always_comb begin
    code = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FUNCT_W'(FN_ADD): code = ALU_ADD;
          FUNCT_W'(FN_SUB): code = ALU_SUB;
          FUNCT_W'(FN_AND): code = ALU_AND;
          FUNCT_W'(FN_OR):  code = ALU_OR;
          FUNCT_W'(FN_SLT): code = ALU_SLT;
          default:          code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_ctrl_c_o = ALU_CTRL_W'(code);

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// for R, LW, SW, BEQ, ADDI and J, stalling on the memory ready handshake.
module unidad_control_multiciclo
  import control_pkg::*;
#(
  parameter int unsigned OPCODE_W   = 6,
  parameter int unsigned FUNCT_W    = 6,
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [OPCODE_W-1:0]   OPcode,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic                  reg_dst,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            pc_source,
  output logic                  instr_done,
  output logic                  illegal_op,
  output logic [3:0]            state_o
);

  state_e state_q, state_d;
  ctrl_t  ctrl_c;
  logic [ALU_CTRL_W-1:0] dec_alu_c;

  logic op_r, op_lw, op_sw, op_beq, op_addi, op_j, op_legal;

  assign op_r     = (OPcode == OPCODE_W'(OP_R));
  assign op_lw    = (OPcode == OPCODE_W'(OP_LW));
  assign op_sw    = (OPcode == OPCODE_W'(OP_SW));
  assign op_beq   = (OPcode == OPCODE_W'(OP_BEQ));
  assign op_addi  = (OPcode == OPCODE_W'(OP_ADDI));
  assign op_j     = (OPcode == OPCODE_W'(OP_J));
  assign op_legal = op_r | op_lw | op_sw | op_beq | op_addi | op_j;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; unused encodings recover to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (en) state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (op_r)               state_d = S_EXEC_R;
        else if (op_lw | op_sw) state_d = S_MEM_ADDR;
        else if (op_beq)        state_d = S_BRANCH;
        else if (op_addi)       state_d = S_EXEC_I;
        else if (op_j)          state_d = S_JUMP;
        else                    state_d = S_FETCH;
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     state_d = S_FETCH;
      S_MEM_ADDR: state_d = op_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_WB_MEM:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  // Moore outputs, with mem_ready/zero/opcode qualifications where required
  always_comb begin
    ctrl_c = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_read   = 1'b1;
        ctrl_c.alu_src_a  = 1'b0;
        ctrl_c.alu_src_b  = SRCB_FOUR;
        ctrl_c.alu_active = 1'b1;
        ctrl_c.alu_op     = ALUOP_ADD;
        ctrl_c.pc_source  = PCSRC_ALU;
        ctrl_c.ir_write   = mem_ready;
        ctrl_c.pc_write   = mem_ready;
      end
      S_DECODE: begin
        ctrl_c.alu_src_b  = SRCB_IMM_SH2;
        ctrl_c.alu_active = 1'b1;
        ctrl_c.alu_op     = ALUOP_ADD;
        ctrl_c.illegal_op = ~op_legal;
      end
      S_EXEC_R: begin
        ctrl_c.alu_src_a  = 1'b1;
        ctrl_c.alu_src_b  = SRCB_REG;
        ctrl_c.alu_active = 1'b1;
        ctrl_c.alu_op     = ALUOP_FUNCT;
      end
      S_WB_R: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = 1'b1;
        ctrl_c.instr_done = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl_c.alu_src_a  = 1'b1;
        ctrl_c.alu_src_b  = SRCB_IMM;
        ctrl_c.alu_active = 1'b1;
        ctrl_c.alu_op     = ALUOP_ADD;
      end
      S_WB_I: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.instr_done = 1'b1;
      end
      S_MEM_RD: ctrl_c.mem_read = 1'b1;
      S_WB_MEM: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_c.mem_write  = 1'b1;
        ctrl_c.instr_done = mem_ready;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a  = 1'b1;
        ctrl_c.alu_src_b  = SRCB_REG;
        ctrl_c.alu_active = 1'b1;
        ctrl_c.alu_op     = ALUOP_SUB;
        ctrl_c.pc_source  = PCSRC_ALUOUT;
        ctrl_c.pc_write   = zero;
        ctrl_c.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_c.pc_source  = PCSRC_JUMP;
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.instr_done = 1'b1;
      end
      default: ctrl_c = '0;
    endcase
  end

  control_alu_decoder #(
    .FUNCT_W    (FUNCT_W),
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_dec (
    .alu_op_i     (ctrl_c.alu_op),
    .funct_i      (funct),
    .alu_ctrl_c_o (dec_alu_c)
  );

  // ALU control is forced to zero in states that do not use the ALU
  assign alu_control = ctrl_c.alu_active ? dec_alu_c : '0;
  assign pc_write    = ctrl_c.pc_write;
  assign ir_write    = ctrl_c.ir_write;
  assign mem_read    = ctrl_c.mem_read;
  assign mem_write   = ctrl_c.mem_write;
  assign reg_write   = ctrl_c.reg_write;
  assign mem_to_reg  = ctrl_c.mem_to_reg;
  assign reg_dst     = ctrl_c.reg_dst;
  assign alu_src_a   = ctrl_c.alu_src_a;
  assign alu_src_b   = ctrl_c.alu_src_b;
  assign pc_source   = ctrl_c.pc_source;
  assign instr_done  = ctrl_c.instr_done;
  assign illegal_op  = ctrl_c.illegal_op;
  assign state_o     = state_q;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Bench for the multi-cycle control unit: a per-instruction model expands each
// instruction into its expected per-cycle control words and latency.
module tb_unidad_control_multiciclo;
  import control_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, en, zero, mem_ready;
  logic [5:0] OPcode, funct;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg;
  logic       reg_dst, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  unidad_control_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .en(en), .OPcode(OPcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_source(pc_source),
    .instr_done(instr_done), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_source;
    logic       instr_done, illegal_op;
  } outs_t;

  typedef struct {
    outs_t      exp;
    bit         alu_care;
    bit         idle;
    bit         mr;
    bit         en;
    bit         z;
    logic [5:0] opc;
    logic [5:0] fn;
    bit         first;
    int         lat;
    string      tag;
  } cyc_t;

  int   errors = 0;
  int   checks = 0;
  cyc_t c;
  cyc_t q[$];
  logic [5:0] cur_op, cur_fn;
  bit   en_rand, cur_en;

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Spec latency from FETCH entry to instr_done with no stalls; 0 = never completes
  function automatic int base_lat(input logic [5:0] op);
    case (op)
      6'b000000: return 4;
      6'b001000: return 4;
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      default:   return 0;
    endcase
  endfunction

  function automatic outs_t sample();
    return {pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, reg_dst,
            alu_src_a, alu_src_b, alu_control, pc_source, instr_done, illegal_op};
  endfunction

  task automatic new_cyc(input string tag, input bit mr);
    c.exp = '0; c.alu_care = 1'b0; c.idle = 1'b0; c.mr = mr;
    c.en = en_rand ? 1'($urandom_range(0, 1)) : cur_en;
    c.z = 1'($urandom_range(0, 1)); c.opc = cur_op; c.fn = cur_fn;
    c.first = 1'b0; c.lat = 0; c.tag = tag;
  endtask

  task automatic push_idle(input bit en_v);
    new_cyc("IDLE", 1'($urandom_range(0, 1)));
    c.en = en_v; c.idle = 1'b1; c.alu_care = 1'b1;
    q.push_back(c);
  endtask

  // Expand one instruction into expected cycles (fw fetch stalls, mw memory stalls)
  task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int fw, input int mw);
    int  lat;
    bit  is_mem;
    cur_op = op; cur_fn = fn;
    is_mem = (op == 6'b100011) || (op == 6'b101011);
    lat = base_lat(op);
    if (lat != 0) lat = lat + fw + (is_mem ? mw : 0);
    for (int i = 0; i <= fw; i++) begin
      new_cyc("FETCH", i == fw);
      c.exp.mem_read = 1'b1; c.exp.alu_src_b = 2'b01; c.exp.alu_control = 3'b010;
      c.alu_care = 1'b1; c.exp.ir_write = c.mr; c.exp.pc_write = c.mr;
      if (i == 0) begin c.first = 1'b1; c.lat = lat; end
      q.push_back(c);
    end
    new_cyc("DECODE", 1'($urandom_range(0, 1)));
    c.exp.alu_src_b = 2'b11; c.exp.alu_control = 3'b010; c.alu_care = 1'b1;
    c.exp.illegal_op = (base_lat(op) == 0);
    q.push_back(c);
    case (op)
      6'b000000: begin
        new_cyc("EXEC_R", 1'($urandom_range(0, 1)));
        c.exp.alu_src_a = 1'b1; c.exp.alu_control = ref_alu(fn); c.alu_care = 1'b1;
        q.push_back(c);
        new_cyc("WB_R", 1'($urandom_range(0, 1)));
        c.exp.reg_write = 1'b1; c.exp.reg_dst = 1'b1; c.exp.instr_done = 1'b1;
        q.push_back(c);
      end
      6'b001000: begin
        new_cyc("EXEC_I", 1'($urandom_range(0, 1)));
        c.exp.alu_src_a = 1'b1; c.exp.alu_src_b = 2'b10; c.exp.alu_control = 3'b010;
        c.alu_care = 1'b1;
        q.push_back(c);
        new_cyc("WB_I", 1'($urandom_range(0, 1)));
        c.exp.reg_write = 1'b1; c.exp.instr_done = 1'b1;
        q.push_back(c);
      end
      6'b100011, 6'b101011: begin
        new_cyc("MEM_ADDR", 1'($urandom_range(0, 1)));
        c.exp.alu_src_a = 1'b1; c.exp.alu_src_b = 2'b10; c.exp.alu_control = 3'b010;
        c.alu_care = 1'b1;
        q.push_back(c);
        for (int i = 0; i <= mw; i++) begin
          new_cyc(op == 6'b100011 ? "MEM_RD" : "MEM_WR", i == mw);
          if (op == 6'b100011) c.exp.mem_read = 1'b1;
          else begin c.exp.mem_write = 1'b1; c.exp.instr_done = c.mr; end
          q.push_back(c);
        end
        if (op == 6'b100011) begin
          new_cyc("WB_MEM", 1'($urandom_range(0, 1)));
          c.exp.reg_write = 1'b1; c.exp.mem_to_reg = 1'b1; c.exp.instr_done = 1'b1;
          q.push_back(c);
        end
      end
      6'b000100: begin
        new_cyc("BRANCH", 1'($urandom_range(0, 1)));
        c.z = z; c.exp.alu_src_a = 1'b1; c.exp.alu_control = 3'b110; c.alu_care = 1'b1;
        c.exp.pc_source = 2'b01; c.exp.pc_write = z; c.exp.instr_done = 1'b1;
        q.push_back(c);
      end
      6'b000010: begin
        new_cyc("JUMP", 1'($urandom_range(0, 1)));
        c.exp.pc_source = 2'b10; c.exp.pc_write = 1'b1; c.exp.instr_done = 1'b1;
        q.push_back(c);
      end
      default: ;
    endcase
  endtask

  task automatic check_outs(input string tag, input outs_t obs, input outs_t exp, input outs_t m);
    checks++;
    assert ((17'(obs) & 17'(m)) === (17'(exp) & 17'(m)))
    else begin
      errors++;
      $error("FAIL %s outs obs=%h exp=%h mask=%h", tag, obs, exp, m);
    end
  endtask

  task automatic check_idle_state(input string tag);
    checks++;
    assert (state_o === 4'(S_IDLE))
    else begin
      errors++;
      $error("FAIL %s state_o obs=%0d exp=%0d", tag, state_o, 4'(S_IDLE));
    end
  endtask

  task automatic run_queue();
    cyc_t  k;
    outs_t obs, m;
    int    ic, el;
    ic = 0; el = 0;
    while (q.size() > 0) begin
      k = q.pop_front();
      en = k.en; OPcode = k.opc; funct = k.fn; zero = k.z; mem_ready = k.mr;
      if (k.first) begin ic = 0; el = k.lat; end
      ic++;
      @(negedge clk);
      obs = sample();
      m = '1;
      if (!k.alu_care) m.alu_control = '0;
      check_outs(k.tag, obs, k.exp, m);
      if (k.idle) check_idle_state(k.tag);
      checks++;
      assert ((mem_read & mem_write) === 1'b0)
      else begin errors++; $error("FAIL %s rd_wr_excl obs=%b exp=0", k.tag, mem_read & mem_write); end
      checks++;
      assert ((reg_write & pc_write) === 1'b0)
      else begin errors++; $error("FAIL %s rw_pcw_excl obs=%b exp=0", k.tag, reg_write & pc_write); end
      if (obs.instr_done) begin
        checks++;
        assert (ic === el)
        else begin errors++; $error("FAIL %s latency obs=%0d exp=%0d", k.tag, ic, el); end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] op, fn;
    outs_t      zeros;
    zeros = '0;
    rst_n = 1'b0; en = 1'b0; OPcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    en_rand = 1'b0; cur_en = 1'b0; cur_op = '0; cur_fn = '0;

    // Held in reset: everything zero, IDLE
    repeat (2) @(posedge clk);
    #1;
    en = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check_outs("reset", sample(), zeros, '1);
    check_idle_state("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // IDLE holds while en is low, leaves on en
    push_idle(1'b0);
    push_idle(1'b0);
    push_idle(1'b1);
    en_rand = 1'b1;
    gen_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
    gen_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
    gen_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
    gen_instr(6'b000100, 6'b000000, 1'b0, 1, 0);
    gen_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
    gen_instr(6'b101011, 6'b000000, 1'b0, 2, 1);
    gen_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
    en_rand = 1'b0; cur_en = 1'b0;
    gen_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
    gen_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
    en_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: fn = 6'b100000;
        1: fn = 6'b100010;
        2: fn = 6'b100100;
        3: fn = 6'b100101;
        4: fn = 6'b101010;
        default: fn = 6'($urandom);
      endcase
      gen_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    // SW stalled in its write wait; the completing cycle is dropped
    gen_instr(6'b101011, 6'b000000, 1'b0, 0, 2);
    void'(q.pop_back());
    run_queue();

    // Async reset in the middle of the write wait
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("rst_mid_sw", sample(), zeros, '1);
    check_idle_state("rst_mid_sw");
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_outs("rst_hold", sample(), zeros, '1);
      check_idle_state("rst_hold");
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    en_rand = 1'b0;
    push_idle(1'b0);
    push_idle(1'b1);
    en_rand = 1'b1;
    gen_instr(6'b001000, 6'b000000, 1'b0, 1, 0);
    gen_instr(6'b000000, 6'b100100, 1'b0, 0, 0);
    run_queue();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
